// File: rtl/ps2_mouse_tx_if.sv
`default_nettype none
// =============================================================================
// ps2_mouse_tx_if : request/status and PS/2 line signals of ps2_mouse_tx
// Rev 1.0
// =============================================================================
interface ps2_mouse_tx_if;
   logic       send;
   logic [8:0] delta_x;
   logic [8:0] delta_y;
   logic [2:0] buttons;
   logic       ps2_clk_in;
   logic       ps2_clk_drive_low;
   logic       ps2_dat_drive_low;
   logic       busy;
   logic       done;
   logic       aborted;

   modport master (
      output send, delta_x, delta_y, buttons, ps2_clk_in,
      input  ps2_clk_drive_low, ps2_dat_drive_low, busy, done, aborted
   );

   modport slave (
      input  send, delta_x, delta_y, buttons, ps2_clk_in,
      output ps2_clk_drive_low, ps2_dat_drive_low, busy, done, aborted
   );
endinterface
`default_nettype wire

// File: rtl/ps2_mouse_tx.sv
`default_nettype none
// =============================================================================
// ps2_mouse_tx : device-side PS/2 transmitter for 3-byte mouse movement packets
// Rev 1.0
// =============================================================================
module ps2_mouse_tx #(
   parameter int HALF_PERIOD = 2000,
   parameter int GAP_CYCLES  = 4000
) (
   input  logic          CLOCK_50,
   input  logic          resetn,
   ps2_mouse_tx_if.slave bus
);

   localparam int MAX_CNT = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
   localparam int CW      = $clog2(MAX_CNT + 1);
   // The single WAIT_BUS cycle after GAP is part of the inter-byte idle time.
   localparam int GAP_LEN = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 1;

   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LEN - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] GUARD     = CW'(2);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_BUS = 3'd1,
      BIT_HIGH = 3'd2,
      BIT_LOW  = 3'd3,
      GAP      = 3'd4,
      DONE     = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [1:0]    byte_q, byte_d;
   logic [7:0]    b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
   logic          sync1_q, sync2_q;
   logic          clk_low_q, dat_low_q, busy_q, done_q, aborted_q;
   logic          aborted_d;
   logic [7:0]    cur_byte_d;
   logic          frame_bit_d;

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         byte_q    <= '0;
         b0_q      <= '0;
         b1_q      <= '0;
         b2_q      <= '0;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         clk_low_q <= 1'b0;
         dat_low_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         byte_q    <= byte_d;
         b0_q      <= b0_d;
         b1_q      <= b1_d;
         b2_q      <= b2_d;
         sync1_q   <= bus.ps2_clk_in;
         sync2_q   <= sync1_q;
         clk_low_q <= (state_d == BIT_LOW);
         dat_low_q <= ((state_d == BIT_HIGH) || (state_d == BIT_LOW)) && !frame_bit_d;
         busy_q    <= (state_d != IDLE);
         done_q    <= (state_d == DONE);
         aborted_q <= aborted_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      b0_d      = b0_q;
      b1_d      = b1_q;
      b2_d      = b2_q;
      aborted_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.send) begin
               b0_d    = {2'b00, bus.delta_y[8], bus.delta_x[8], 1'b1, bus.buttons};
               b1_d    = bus.delta_x[7:0];
               b2_d    = bus.delta_y[7:0];
               cnt_d   = '0;
               bit_d   = '0;
               byte_d  = '0;
               state_d = WAIT_BUS;
            end
         end
         WAIT_BUS: begin
            if (sync2_q) begin
               cnt_d   = '0;
               state_d = BIT_HIGH;
            end
         end
         BIT_HIGH: begin
            // The first two cycles still see our own low drive through the synchronizer.
            if (!sync2_q && (cnt_q >= GUARD)) begin
               aborted_d = 1'b1;
               cnt_d     = '0;
               bit_d     = '0;
               byte_d    = '0;
               state_d   = IDLE;
            end else if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = BIT_LOW;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         BIT_LOW: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (bit_q == 4'd10) begin
                  bit_d = '0;
                  if (byte_q == 2'd2) begin
                     byte_d  = '0;
                     state_d = DONE;
                  end else begin
                     byte_d  = byte_q + 2'd1;
                     state_d = GAP;
                  end
               end else begin
                  bit_d   = bit_q + 4'd1;
                  state_d = BIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = WAIT_BUS;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Frame bit for the upcoming cycle: start, data LSB first, odd parity, stop.
   always_comb begin
      case (byte_d)
         2'd0:    cur_byte_d = b0_q;
         2'd1:    cur_byte_d = b1_q;
         default: cur_byte_d = b2_q;
      endcase
      case (bit_d)
         4'd0:    frame_bit_d = 1'b0;
         4'd1:    frame_bit_d = cur_byte_d[0];
         4'd2:    frame_bit_d = cur_byte_d[1];
         4'd3:    frame_bit_d = cur_byte_d[2];
         4'd4:    frame_bit_d = cur_byte_d[3];
         4'd5:    frame_bit_d = cur_byte_d[4];
         4'd6:    frame_bit_d = cur_byte_d[5];
         4'd7:    frame_bit_d = cur_byte_d[6];
         4'd8:    frame_bit_d = cur_byte_d[7];
         4'd9:    frame_bit_d = ~^cur_byte_d;
         default: frame_bit_d = 1'b1;
      endcase
   end

   assign bus.ps2_clk_drive_low = clk_low_q;
   assign bus.ps2_dat_drive_low = dat_low_q;
   assign bus.busy              = busy_q;
   assign bus.done              = done_q;
   assign bus.aborted           = aborted_q;

endmodule
`default_nettype wire

// File: doc/ps2_mouse_tx.md
PS2_MOUSE_TX -- requirements
Module: ps2_mouse_tx

Interface
REQ-001 The block SHALL have parameter HALF_PERIOD, default 2000, meaning CLOCK_50 cycles per PS/2 clock half-phase (12.5 kHz); legal values are 4 or more.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 4000, meaning idle CLOCK_50 cycles between the bytes of one packet.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- CLOCK_50, in, 1, system clock, all logic on its rising edge.
- resetn, in, 1, synchronous, active-low reset.
- send, in, 1, one-cycle request to transmit one packet.
- delta_x, in, 9, two's-complement X movement.
- delta_y, in, 9, two's-complement Y movement (positive = up).
- buttons, in, 3, {middle, right, left}.
- ps2_clk_in, in, 1, sensed PS/2 clock line (asynchronous).
- ps2_clk_drive_low, out, 1, 1 = pull the PS/2 clock line low; 0 = release it.
- ps2_dat_drive_low, out, 1, 1 = pull the PS/2 data line low; 0 = release it.
- busy, out, 1, packet in progress.
- done, out, 1, one-cycle pulse when a packet completes.
- aborted, out, 1, one-cycle pulse when the host inhibits mid-packet.

Function
REQ-004 The block SHALL pass ps2_clk_in through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-005 The block SHALL accept send only in IDLE, latching delta_x, delta_y and buttons that cycle; send SHALL be ignored while busy=1.
REQ-006 Byte0 SHALL be {1'b0, 1'b0, delta_y[8], delta_x[8], 1'b1, buttons[2], buttons[1], buttons[0]}; the overflow bits are always 0.
REQ-007 Byte1 SHALL be delta_x[7:0], byte2 SHALL be delta_y[7:0], and the bytes SHALL be transmitted in the order 0, 1, 2.
REQ-008 Each byte SHALL be sent as an 11-bit frame in this order: start bit 0, data bits LSB first, odd parity bit, stop bit 1.
REQ-009 Each frame bit SHALL take 2*HALF_PERIOD cycles, split as follows:
- BIT_HIGH phase: HALF_PERIOD cycles, clock released, data updated on the first cycle.
- BIT_LOW phase: HALF_PERIOD cycles, clock driven low, data held.
REQ-010 Data bit value 0 SHALL be signalled as ps2_dat_drive_low=1, and value 1 as ps2_dat_drive_low=0.
REQ-011 The state machine SHALL have states IDLE, WAIT_BUS, BIT_HIGH, BIT_LOW, GAP and DONE, with these transitions:
- IDLE -> WAIT_BUS on an accepted send.
- WAIT_BUS -> BIT_HIGH when the synchronized clock is 1; otherwise stay in WAIT_BUS.
- BIT_HIGH -> BIT_LOW when its half-period count expires.
- BIT_LOW -> BIT_HIGH after bits 0-9 of a frame.
- BIT_LOW -> GAP after bit 10 of byte 0 or byte 1.
- BIT_LOW -> DONE after bit 10 of byte 2.
- GAP -> WAIT_BUS after GAP_CYCLES.
- DONE -> IDLE after one cycle.
REQ-012 In IDLE, WAIT_BUS, GAP and DONE, both drive_low outputs SHALL be 0.
REQ-013 busy SHALL be 1 in every state except IDLE; done SHALL be 1 only during the DONE cycle.
REQ-014 If the synchronized clock reads 0 during BIT_HIGH on any cycle from the 3rd onward, the block SHALL:
- release both lines on the next edge;
- pulse aborted for one cycle;
- go to IDLE with no done pulse.
REQ-015 The bit counter SHALL be 4 bits wide (0-10) and the byte counter 2 bits wide (0-2); the phase counter SHALL be wide enough for max(HALF_PERIOD, GAP_CYCLES).
REQ-016 With the bus idle, the packet timing SHALL be as follows, taking the edge that samples send as t0:
- busy rises at t0+1.
- BIT_HIGH begins at t0+2.
- done is high in cycle t0+2+33*2*HALF_PERIOD+2*GAP_CYCLES.
REQ-017 If send and a host inhibit occur together while in IDLE, the block SHALL accept send and wait in WAIT_BUS.

Reset
REQ-018 On resetn=0 at a clock edge, the block SHALL set state=IDLE and all outputs to 0 (busy, done, aborted, both drive_low) and clear all counters; this SHALL apply mid-packet too.
REQ-019 After reset is released, the block SHALL accept send on the first IDLE cycle.

Verification
REQ-020 Basic packet (HALF_PERIOD=4, GAP_CYCLES=8, bus idle): delta_x=0x005, delta_y=0x1FD, buttons=001, send at t0 -> the bench SHALL see:
- bytes 0x29 (parity 0), 0x05 (parity 1), 0xFD (parity 0), decoded on clock falling edges;
- done at t0+282.
REQ-021 Busy blocking: a second send during a packet with different inputs -> the bench SHALL see it ignored, the first packet's bytes unchanged, and only one done pulse.
REQ-022 Host inhibit mid-packet: ps2_clk_in held low for 6 cycles during the BIT_HIGH of byte1 bit3 -> the bench SHALL see:
- both lines released within 1 cycle of detection;
- one aborted pulse, no done pulse;
- busy=0.
REQ-023 Bus held before start: ps2_clk_in=0 at send, released 20 cycles later -> the bench SHALL see the block stay in WAIT_BUS and start BIT_HIGH 3 cycles after release (synchronizer latency plus transition).
REQ-024 Reset mid-packet: resetn=0 for 1 cycle during byte2 -> the bench SHALL see all outputs 0 on the next edge; a following send SHALL produce a complete, correct packet.
REQ-025 Sign and button extremes: delta_x=0x100, delta_y=0x0FF, buttons=111 -> the bench SHALL see bytes 0x1F, 0x00, 0xFF with parities 0, 1, 1.
